// File: rtl/multiboot_pkg.sv
// multiboot_pkg: shared types and constants for the multiboot reboot front end
package multiboot_pkg;
  localparam int ADDR_W = 24;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [2:0] {IDLE, HOLD, SETUP, PULSE, TAIL, DONE} state_t;
  localparam addr_t STRIDE_LX25 = 24'h0B0000;
  localparam addr_t STRIDE_LX16 = 24'h098000;
  // slot * stride as shift/add; a constant stride folds this down to a few adders
  function automatic addr_t slot_offset(input logic [3:0] slot, input addr_t stride);
    slot_offset = '0;
    for (int i = 0; i < 4; i++)
      if (slot[i]) slot_offset = slot_offset + (stride << i);
  endfunction
endpackage

// File: rtl/slot_addr_calc.sv
// slot_addr_calc: registered slot-to-flash-address map with slot range check
module slot_addr_calc import multiboot_pkg::*; #(
  parameter addr_t SPI_BASE = '0,
  parameter addr_t SLOT_STRIDE = STRIDE_LX25,
  parameter int NUM_SLOTS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] slot,
  output logic       in_range,
  output addr_t      addr
);
  assign in_range = {1'b0, slot} < 5'(NUM_SLOTS);
  always_ff @(posedge clk)
    if (rst) addr <= SPI_BASE;
    else if (load) addr <= SPI_BASE + slot_offset(slot, SLOT_STRIDE);
endmodule

// File: rtl/reboot_request_ctrl.sv
// reboot_request_ctrl: host/key reboot request front end for the ICAP multiboot sequencer.
// Define REBOOT_KEYHOLD_EN to enable the held key-combo path (HOLD state).
module reboot_request_ctrl import multiboot_pkg::*; #(
  parameter addr_t       SPI_BASE     = '0,
  parameter addr_t       SLOT_STRIDE  = STRIDE_LX25,
  parameter int          NUM_SLOTS    = 8,
  parameter logic [23:0] HOLD_CYCLES  = 24'd5_000_000,
  parameter int          SETUP_CYCLES = 16,
  parameter int          PULSE_CYCLES = 8,
  parameter int          TAIL_CYCLES  = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req_valid,
  input  logic [3:0] req_slot,
  output logic       req_ready,
  input  logic       key_combo,
  output addr_t      spi_addr,
  output logic       REBOOT,
  output logic       busy,
  output logic       req_err
);
  state_t      state;
  logic [15:0] cnt;
  logic        in_range, key_done, load;
  logic [3:0]  calc_slot;
`ifdef REBOOT_KEYHOLD_EN
  logic [23:0] hcnt;
  assign key_done = state == HOLD && hcnt == HOLD_CYCLES;
`else
  logic unused_key;
  assign unused_key = key_combo | (|HOLD_CYCLES);
  assign key_done = 1'b0;
`endif
  assign calc_slot = key_done ? 4'd0 : req_slot;
  assign load = key_done || (state == IDLE && req_valid && in_range);
  slot_addr_calc #(.SPI_BASE(SPI_BASE), .SLOT_STRIDE(SLOT_STRIDE), .NUM_SLOTS(NUM_SLOTS)) u_calc (
    .clk(CLK), .rst(RESET), .load(load), .slot(calc_slot), .in_range(in_range), .addr(spi_addr)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      REBOOT <= 1'b0;
      busy <= 1'b0;
      req_ready <= 1'b1;
      req_err <= 1'b0;
`ifdef REBOOT_KEYHOLD_EN
      hcnt <= '0;
`endif
    end else begin
      req_err <= 1'b0;
      case (state)
        IDLE:
          if (req_valid && in_range) begin
            state <= SETUP;
            cnt <= '0;
            busy <= 1'b1;
            req_ready <= 1'b0;
          end else if (req_valid) req_err <= 1'b1;
`ifdef REBOOT_KEYHOLD_EN
          else if (key_combo) begin
            state <= HOLD;
            hcnt <= 24'd1;
            busy <= 1'b1;
            req_ready <= 1'b0;
          end
        HOLD:
          if (key_done) begin
            state <= SETUP;
            cnt <= '0;
            hcnt <= '0;
          end else if (!key_combo) begin
            state <= IDLE;
            hcnt <= '0;
            busy <= 1'b0;
            req_ready <= 1'b1;
          end else hcnt <= hcnt + 24'd1;
`endif
        SETUP:
          if (cnt == 16'(SETUP_CYCLES)) begin
            state <= PULSE;
            REBOOT <= 1'b1;
            cnt <= 16'd1;
          end else cnt <= cnt + 16'd1;
        PULSE:
          if (cnt == 16'(PULSE_CYCLES)) begin
            state <= TAIL;
            REBOOT <= 1'b0;
            cnt <= 16'd1;
          end else cnt <= cnt + 16'd1;
        TAIL:
          if (cnt == 16'(TAIL_CYCLES)) state <= DONE;
          else cnt <= cnt + 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_reboot_request_ctrl.sv
// tb_reboot_request_ctrl: directed self-checking bench for reboot_request_ctrl (HOLD_CYCLES = 100)
module tb_reboot_request_ctrl;
  logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, key_combo = 1'b0;
  logic [3:0]  req_slot = 4'd0;
  logic        req_ready, REBOOT, busy, req_err;
  logic [23:0] spi_addr;
  int errors = 0, checks = 0;

  reboot_request_ctrl #(.HOLD_CYCLES(24'd100)) dut (
    .CLK(clk), .RESET(rst), .req_valid(req_valid), .req_slot(req_slot), .req_ready(req_ready),
    .key_combo(key_combo), .spi_addr(spi_addr), .REBOOT(REBOOT), .busy(busy), .req_err(req_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; key_combo = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({REBOOT, busy, req_ready, req_err} !== 4'b0010) begin
      errors++; $display("FAIL reset_flags got=%b want=0010", {REBOOT, busy, req_ready, req_err});
    end
    checks++;
    if (spi_addr !== 24'h000000) begin errors++; $display("FAIL reset_addr got=%h want=000000", spi_addr); end
  endtask

  // host accept at edge N: REBOOT high after edges N+17..N+24, DONE after N+33
  task automatic test_host_slot1();
    do_reset();
    req_valid = 1'b1; req_slot = 4'd1;
    tick(1);
    req_valid = 1'b0;
    checks++;
    if (spi_addr !== 24'h0B0000) begin errors++; $display("FAIL host_addr got=%h want=0b0000", spi_addr); end
    checks++;
    if ({busy, req_ready} !== 2'b10) begin errors++; $display("FAIL host_busy got=%b want=10", {busy, req_ready}); end
    for (int k = 1; k <= 36; k++) begin
      tick(1);
      checks++;
      if (REBOOT !== (k >= 17 && k < 25)) begin
        errors++; $display("FAIL host_pulse k=%0d got=%b want=%b", k, REBOOT, (k >= 17 && k < 25));
      end
    end
  endtask

  // follows test_host_slot1: block sits in DONE
  task automatic test_done_ignore();
    req_valid = 1'b1; req_slot = 4'd2; key_combo = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (k == 5) req_slot = 4'd9;
      checks++;
      if ({REBOOT, busy, req_ready, req_err} !== 4'b0100 || spi_addr !== 24'h0B0000) begin
        errors++; $display("FAIL done_ignore k=%0d flags=%b addr=%h want=0100/0b0000", k, {REBOOT, busy, req_ready, req_err}, spi_addr);
      end
    end
    req_valid = 1'b0; key_combo = 1'b0;
  endtask

  task automatic test_bad_slot();
    do_reset();
    req_valid = 1'b1; req_slot = 4'd9;
    tick(1);
    req_valid = 1'b0;
    checks++;
    if ({req_err, busy, req_ready} !== 3'b101) begin errors++; $display("FAIL bad9_err got=%b want=101", {req_err, busy, req_ready}); end
    tick(1);
    checks++;
    if (req_err !== 1'b0) begin errors++; $display("FAIL bad9_err_len got=%b want=0", req_err); end
    req_valid = 1'b1; req_slot = 4'd8;
    tick(1);
    req_valid = 1'b0;
    checks++;
    if ({req_err, busy} !== 2'b10) begin errors++; $display("FAIL bad8_err got=%b want=10", {req_err, busy}); end
    for (int k = 0; k < 25; k++) begin
      tick(1);
      checks++;
      if (REBOOT !== 1'b0 || spi_addr !== 24'h000000 || busy !== 1'b0) begin
        errors++; $display("FAIL bad_quiet k=%0d reboot=%b addr=%h busy=%b want=0/000000/0", k, REBOOT, spi_addr, busy);
      end
    end
    req_valid = 1'b1; req_slot = 4'd7;
    tick(1);
    req_valid = 1'b0;
    checks++;
    if (spi_addr !== 24'h4D0000 || req_err !== 1'b0) begin
      errors++; $display("FAIL slot7 addr=%h err=%b want=4d0000/0", spi_addr, req_err);
    end
  endtask

  task automatic test_key();
`ifdef REBOOT_KEYHOLD_EN
    do_reset();
    key_combo = 1'b1;
    tick(99);
    key_combo = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL key_hold_busy got=%b want=1", busy); end
    tick(1);
    checks++;
    if ({busy, req_ready} !== 2'b01) begin errors++; $display("FAIL key_release got=%b want=01", {busy, req_ready}); end
    for (int k = 0; k < 30; k++) begin
      tick(1);
      checks++;
      if (REBOOT !== 1'b0) begin errors++; $display("FAIL key_short_pulse k=%0d got=%b want=0", k, REBOOT); end
    end
    key_combo = 1'b1;
    tick(50);
    req_valid = 1'b1; req_slot = 4'd5;
    tick(1);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || spi_addr !== 24'h000000) begin
      errors++; $display("FAIL key_hold_host ready=%b addr=%h want=0/000000", req_ready, spi_addr);
    end
    tick(49);
    key_combo = 1'b0;
    for (int e = 100; e <= 130; e++) begin
      tick(1);
      checks++;
      if (REBOOT !== (e >= 117 && e < 125) || spi_addr !== 24'h000000) begin
        errors++; $display("FAIL key_pulse e=%0d got=%b/%h want=%b/000000", e, REBOOT, spi_addr, (e >= 117 && e < 125));
      end
    end
`else
    do_reset();
    key_combo = 1'b1;
    for (int k = 0; k < 150; k++) begin
      tick(1);
      checks++;
      if ({REBOOT, busy, req_ready} !== 3'b001) begin
        errors++; $display("FAIL key_disabled k=%0d got=%b want=001", k, {REBOOT, busy, req_ready});
      end
    end
    key_combo = 1'b0;
`endif
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_valid = 1'b1; req_slot = 4'd3; key_combo = 1'b1;
    tick(1);
    req_valid = 1'b0;
    checks++;
    if (spi_addr !== 24'h210000 || busy !== 1'b1) begin
      errors++; $display("FAIL simul_addr got=%h/%b want=210000/1", spi_addr, busy);
    end
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (k == 20) key_combo = 1'b0;
      checks++;
      if (REBOOT !== (k >= 17 && k < 25) || spi_addr !== 24'h210000) begin
        errors++; $display("FAIL simul_pulse k=%0d got=%b/%h want=%b/210000", k, REBOOT, spi_addr, (k >= 17 && k < 25));
      end
    end
  endtask

  task automatic test_reset_pulse();
    do_reset();
    req_valid = 1'b1; req_slot = 4'd2;
    tick(1);
    req_valid = 1'b0;
    tick(19);
    checks++;
    if (REBOOT !== 1'b1) begin errors++; $display("FAIL rp_third got=%b want=1", REBOOT); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({REBOOT, busy, req_ready} !== 3'b001) begin
      errors++; $display("FAIL rp_abort got=%b want=001", {REBOOT, busy, req_ready});
    end
    req_valid = 1'b1; req_slot = 4'd4;
    tick(1);
    req_valid = 1'b0;
    checks++;
    if (spi_addr !== 24'h2C0000) begin errors++; $display("FAIL rp_addr got=%h want=2c0000", spi_addr); end
    for (int k = 1; k <= 26; k++) begin
      tick(1);
      checks++;
      if (REBOOT !== (k >= 17 && k < 25)) begin
        errors++; $display("FAIL rp_pulse k=%0d got=%b want=%b", k, REBOOT, (k >= 17 && k < 25));
      end
    end
  endtask

  initial begin
    test_reset();
    test_host_slot1();
    test_done_ignore();
    test_bad_slot();
    test_key();
    test_simultaneous();
    test_reset_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
